ysyx_exu_trap_ctrl: RTL
=======================

// Module: ysyx_exu_trap_ctrl
// PURPOSE
// - Trap sequencer driving the M-mode CSR register file: turns EXU trap/return events into CSR write pulses.
// - Issues a PC redirect to the IFU.
// - Sits between EXU (trap source) and IFU (redirect sink); the CSR block's write/ecall inputs are driven only from here.
// - Handles ECALL, EBREAK, illegal-instruction and MRET with a 3-state FSM and valid/ready handshakes on both sides.
// PARAMETERS
// - XLEN        32     data/PC width (`ysyx_W_WIDTH)
// - CSR_AW      12     CSR address width
// - CAUSE_ECALL 11     mcause for ECALL from M-mode
// - CAUSE_EBRK  3      mcause for EBREAK
// - CAUSE_ILL   2      mcause for illegal instruction
// PORTS
// - clk               in   1       clock
// - rst               in   1       synchronous, active-high reset
// - trap_valid_i      in   1       EXU presents a trap/return event
// - trap_ready_o      out  1       event accepted this cycle when valid&ready
// - trap_kind_i       in   2       0=ECALL 1=EBREAK 2=ILLEGAL 3=MRET
// - trap_pc_i         in   XLEN    PC of the trapping instruction
// - csr_mtvec_i       in   XLEN    current mtvec
// - csr_mepc_i        in   XLEN    current mepc
// - csr_mstatus_i     in   XLEN    current mstatus
// - csr_valid_o       out  1       write strobe (CSR exu_valid)
// - csr_wen_o         out  1       CSR write enable
// - csr_waddr_o       out  CSR_AW  write address port 0
// - csr_wdata_o       out  XLEN    write data port 0
// - csr_waddr1_o      out  CSR_AW  write address port 1
// - csr_wdata1_o      out  XLEN    write data port 1
// - csr_ecallen_o     out  1       mstatus MIE->MPIE save request
// - redir_valid_o     out  1       redirect target valid
// - redir_ready_i     in   1       IFU accepts redirect
// - redir_pc_o        out  XLEN    redirect target
// - flush_o           out  1       pipeline flush, high from accept until redirect handshake
// BEHAVIOUR
// - Reset: state=IDLE; trap_ready_o=1.
//   All other outputs 0: csr_valid_o, csr_wen_o, csr_ecallen_o, redir_valid_o, flush_o; all address/data outputs 0.
// - IDLE: trap_ready_o=1. On trap_valid_i: latch kind and pc, go to CSRWR; flush_o rises next cycle.
// - CSRWR (exactly 1 cycle):
//   - csr_valid_o=1, csr_wen_o=1.
//   - ECALL/EBREAK/ILLEGAL:
//     - waddr=MEPC, wdata={pc[XLEN-1:2],2'b00}.
//     - waddr1=MCAUSE, wdata1=cause (zero-extended).
//     - csr_ecallen_o=1.
//     - Target latched = {mtvec[XLEN-1:2],2'b00}; vectored mode still uses base for sync exceptions.
//   - MRET:
//     - waddr=waddr1=MSTATUS; wdata=mstatus with MIE=MPIE and MPIE=1; other bits unchanged.
//     - csr_ecallen_o=0.
//     - Target latched = mepc.
//   - CSR inputs are sampled in this cycle, not at accept.
//   - Go to REDIR.
// - REDIR: redir_valid_o=1, redir_pc_o held stable.
//   - On redir_ready_i: go to IDLE; flush_o falls the same edge.
//   - If redir_ready_i is high in the first REDIR cycle, the redirect completes in 1 cycle.
// - Latency: accept at edge N; CSR write at edge N+2; earliest redirect handshake at edge N+3.
// - trap_ready_o=0 in CSRWR/REDIR. EXU must hold trap_valid_i; extra events are not accepted, never dropped silently.
// - Back-to-back: IDLE re-entered and ready=1 in the cycle after the redirect handshake; no bubble beyond that.
// - rst mid-operation (any state):
//   - Next cycle is IDLE with all strobes low.
//   - A pending redirect is discarded.
//   - A CSR write not yet strobed is never issued.
// - csr_* and redir_* outputs are registered (no combinational path from trap_valid_i).
// - csr_wen_o is never high without csr_valid_o, and never outside CSRWR.
// STRUCTURE
// - Shared package/macros (ysyx_macro_csr.v):
//   - CSR addresses, MSTATUS MIE/MPIE bit indices.
//   - TRAP_KIND_* encodings, state encoding localparams.
// - Cause mapping (kind -> mcause) is a small combinational function in-module.
// - No sub-module; single FSM plus latch registers.
// TESTING
// - ECALL: pc=0x80000104, mtvec=0x80001001.
//   - CSRWR: mepc<=0x80000104, mcause<=11, ecallen=1.
//   - REDIR: redir_pc=0x80001000. Then mstatus MIE=1 -> MPIE=1, MIE=0.
// - MRET: mepc=0x80000108, mstatus=0x80.
//   - CSR write mstatus=0x88.
//   - Redirect 0x80000108; ecallen stays 0.
// - Backpressure: redir_ready_i low 5 cycles.
//   - redir_valid/pc stable, flush_o high, trap_ready_o=0 throughout.
//   - Second trap_valid held, then accepted exactly 1 cycle after handshake.
// - ILLEGAL with pc=0x80000002: mepc<=0x80000000, mcause<=2. EBREAK: mcause<=3.
// - rst asserted in CSRWR and in REDIR.
//   - Next cycle all outputs at reset values.
//   - No csr_valid_o pulse after reset.
// - Random trap stream with random redir_ready.
//   - Scoreboard: one CSR strobe and one redirect per accepted event, in order.

Source files
------------

// File: rtl/ysyx_exu_trap_ctrl_pkg.sv
// Shared constants for the EXU trap sequencer: CSR addresses, mstatus bit
// positions, trap kind encodings, mcause values and FSM state encoding.
package ysyx_exu_trap_ctrl_pkg;

  localparam int XLEN   = 32;
  localparam int CSR_AW = 12;

  localparam logic [CSR_AW-1:0] CSR_MSTATUS = 12'h300;
  localparam logic [CSR_AW-1:0] CSR_MEPC    = 12'h341;
  localparam logic [CSR_AW-1:0] CSR_MCAUSE  = 12'h342;

  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;

  localparam logic [XLEN-1:0] CAUSE_ECALL = 32'd11;
  localparam logic [XLEN-1:0] CAUSE_EBRK  = 32'd3;
  localparam logic [XLEN-1:0] CAUSE_ILL   = 32'd2;

  typedef enum logic [1:0] {
    TRAP_KIND_ECALL   = 2'd0,
    TRAP_KIND_EBREAK  = 2'd1,
    TRAP_KIND_ILLEGAL = 2'd2,
    TRAP_KIND_MRET    = 2'd3
  } trap_kind_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CSRWR = 2'd1,
    ST_REDIR = 2'd2
  } state_e;

endpackage

// File: rtl/ysyx_exu_trap_ctrl_if.sv
// Bundles the EXU trap handshake, CSR write port and IFU redirect port.
// slave is the trap controller; master is the surrounding pipeline/CSR side.
interface ysyx_exu_trap_ctrl_if;
  import ysyx_exu_trap_ctrl_pkg::*;

  logic              trap_valid_i;
  logic              trap_ready_o;
  logic [1:0]        trap_kind_i;
  logic [XLEN-1:0]   trap_pc_i;
  logic [XLEN-1:0]   csr_mtvec_i;
  logic [XLEN-1:0]   csr_mepc_i;
  logic [XLEN-1:0]   csr_mstatus_i;
  logic              csr_valid_o;
  logic              csr_wen_o;
  logic [CSR_AW-1:0] csr_waddr_o;
  logic [XLEN-1:0]   csr_wdata_o;
  logic [CSR_AW-1:0] csr_waddr1_o;
  logic [XLEN-1:0]   csr_wdata1_o;
  logic              csr_ecallen_o;
  logic              redir_valid_o;
  logic              redir_ready_i;
  logic [XLEN-1:0]   redir_pc_o;
  logic              flush_o;

  modport slave (
    input  trap_valid_i, trap_kind_i, trap_pc_i,
    input  csr_mtvec_i, csr_mepc_i, csr_mstatus_i, redir_ready_i,
    output trap_ready_o, csr_valid_o, csr_wen_o, csr_waddr_o, csr_wdata_o,
    output csr_waddr1_o, csr_wdata1_o, csr_ecallen_o,
    output redir_valid_o, redir_pc_o, flush_o
  );

  modport master (
    output trap_valid_i, trap_kind_i, trap_pc_i,
    output csr_mtvec_i, csr_mepc_i, csr_mstatus_i, redir_ready_i,
    input  trap_ready_o, csr_valid_o, csr_wen_o, csr_waddr_o, csr_wdata_o,
    input  csr_waddr1_o, csr_wdata1_o, csr_ecallen_o,
    input  redir_valid_o, redir_pc_o, flush_o
  );
endinterface

// File: rtl/ysyx_exu_trap_ctrl.sv
// Trap sequencer: accepts ECALL/EBREAK/ILLEGAL/MRET events, issues one CSR
// write strobe, then holds a PC redirect to the IFU until it is taken.
module ysyx_exu_trap_ctrl
  import ysyx_exu_trap_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst,
  ysyx_exu_trap_ctrl_if.slave bus
);

  state_e            state_reg, state_next;
  trap_kind_e        kind_reg, kind_next;
  logic [XLEN-1:0]   pc_reg, pc_next;
  logic              csr_valid_reg, csr_valid_next;
  logic              csr_ecallen_reg, csr_ecallen_next;
  logic [CSR_AW-1:0] csr_waddr_reg, csr_waddr_next;
  logic [XLEN-1:0]   csr_wdata_reg, csr_wdata_next;
  logic [CSR_AW-1:0] csr_waddr1_reg, csr_waddr1_next;
  logic [XLEN-1:0]   csr_wdata1_reg, csr_wdata1_next;
  logic              redir_valid_reg, redir_valid_next;
  logic [XLEN-1:0]   redir_pc_reg, redir_pc_next;
  logic              flush_reg, flush_next;
  logic [XLEN-1:0]   mret_status;

  // Low address bits are forced to zero, so they never influence the outputs.
  logic unused_bits;
  assign unused_bits = ^{bus.csr_mtvec_i[1:0]};

  function automatic logic [XLEN-1:0] cause_of(input trap_kind_e kind);
    case (kind)
      TRAP_KIND_ECALL:  return CAUSE_ECALL;
      TRAP_KIND_EBREAK: return CAUSE_EBRK;
      default:          return CAUSE_ILL;
    endcase
  endfunction

  always_comb begin
    mret_status               = bus.csr_mstatus_i;
    mret_status[MSTATUS_MIE]  = bus.csr_mstatus_i[MSTATUS_MPIE];
    mret_status[MSTATUS_MPIE] = 1'b1;
  end

  always_comb begin
    state_next       = state_reg;
    kind_next        = kind_reg;
    pc_next          = pc_reg;
    csr_valid_next   = 1'b0;
    csr_ecallen_next = 1'b0;
    csr_waddr_next   = csr_waddr_reg;
    csr_wdata_next   = csr_wdata_reg;
    csr_waddr1_next  = csr_waddr1_reg;
    csr_wdata1_next  = csr_wdata1_reg;
    redir_valid_next = redir_valid_reg;
    redir_pc_next    = redir_pc_reg;
    flush_next       = flush_reg;
    case (state_reg)
      ST_IDLE: begin
        if (bus.trap_valid_i) begin
          kind_next  = trap_kind_e'(bus.trap_kind_i);
          pc_next    = {bus.trap_pc_i[XLEN-1:2], 2'b00};
          flush_next = 1'b1;
          state_next = ST_CSRWR;
        end
      end
      ST_CSRWR: begin
        // CSR values are sampled here rather than at accept, so an older
        // in-flight CSR update is already visible.
        csr_valid_next = 1'b1;
        if (kind_reg == TRAP_KIND_MRET) begin
          csr_waddr_next  = CSR_MSTATUS;
          csr_wdata_next  = mret_status;
          csr_waddr1_next = CSR_MSTATUS;
          csr_wdata1_next = mret_status;
          redir_pc_next   = bus.csr_mepc_i;
        end else begin
          csr_waddr_next   = CSR_MEPC;
          csr_wdata_next   = pc_reg;
          csr_waddr1_next  = CSR_MCAUSE;
          csr_wdata1_next  = cause_of(kind_reg);
          csr_ecallen_next = 1'b1;
          redir_pc_next    = {bus.csr_mtvec_i[XLEN-1:2], 2'b00};
        end
        state_next = ST_REDIR;
      end
      ST_REDIR: begin
        if (!redir_valid_reg) begin
          redir_valid_next = 1'b1;
        end else if (bus.redir_ready_i) begin
          redir_valid_next = 1'b0;
          flush_next       = 1'b0;
          state_next       = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= ST_IDLE;
      kind_reg        <= TRAP_KIND_ECALL;
      pc_reg          <= '0;
      csr_valid_reg   <= 1'b0;
      csr_ecallen_reg <= 1'b0;
      csr_waddr_reg   <= '0;
      csr_wdata_reg   <= '0;
      csr_waddr1_reg  <= '0;
      csr_wdata1_reg  <= '0;
      redir_valid_reg <= 1'b0;
      redir_pc_reg    <= '0;
      flush_reg       <= 1'b0;
    end else begin
      state_reg       <= state_next;
      kind_reg        <= kind_next;
      pc_reg          <= pc_next;
      csr_valid_reg   <= csr_valid_next;
      csr_ecallen_reg <= csr_ecallen_next;
      csr_waddr_reg   <= csr_waddr_next;
      csr_wdata_reg   <= csr_wdata_next;
      csr_waddr1_reg  <= csr_waddr1_next;
      csr_wdata1_reg  <= csr_wdata1_next;
      redir_valid_reg <= redir_valid_next;
      redir_pc_reg    <= redir_pc_next;
      flush_reg       <= flush_next;
    end
  end

  assign bus.trap_ready_o  = (state_reg == ST_IDLE);
  assign bus.csr_valid_o   = csr_valid_reg;
  assign bus.csr_wen_o     = csr_valid_reg;
  assign bus.csr_waddr_o   = csr_waddr_reg;
  assign bus.csr_wdata_o   = csr_wdata_reg;
  assign bus.csr_waddr1_o  = csr_waddr1_reg;
  assign bus.csr_wdata1_o  = csr_wdata1_reg;
  assign bus.csr_ecallen_o = csr_ecallen_reg;
  assign bus.redir_valid_o = redir_valid_reg;
  assign bus.redir_pc_o    = redir_pc_reg;
  assign bus.flush_o       = flush_reg;

endmodule
